// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator: pixel divider, h/v counters, sync/blank/strobe decode.
// Optional colour-bar test pattern on red/green/blue when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  output logic             HS,
  output logic             VS,
  output logic             blank,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [7:0]       red,
  output logic [7:0]       green,
  output logic [7:0]       blue
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             tick;
  logic             hs_win;
  logic             vs_win;

  // With CLK_DIV=1 div_q is pinned at 0, so the tick is permanently high.
  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign hs_win      = (h_q >= H_SYNC_START) && (h_q < H_SYNC_END);
  assign vs_win      = (v_q >= V_SYNC_START) && (v_q < V_SYNC_END);
  assign HS          = HS_POL ? hs_win : ~hs_win;
  assign VS          = VS_POL ? vs_win : ~vs_win;
  assign blank       = (h_q >= H_ACT_END) || (v_q >= V_ACT_END);
  assign row         = v_q;
  assign col         = h_q;
  assign pix_tick    = tick;
  assign line_start  = tick && (h_q == '0);
  assign frame_start = tick && (h_q == '0) && (v_q == '0);

`ifdef VGA_TEST_PATTERN_EN
  // Bar width falls back to one pixel when the line is narrower than eight pixels.
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;

  logic [CNT_W-1:0] bar_full;
  logic [2:0]       bar;

  assign bar_full = h_q / CNT_W'(BAR_W);
  assign bar      = (bar_full > CNT_W'(7)) ? 3'd7 : bar_full[2:0];
  assign red      = (!blank && bar[2]) ? 8'hFF : 8'h00;
  assign green    = (!blank && bar[1]) ? 8'hFF : 8'h00;
  assign blue     = (!blank && bar[0]) ? 8'hFF : 8'h00;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen with random reset pulses.
// Two reduced-size instances (CLK_DIV=3 and CLK_DIV=1) against a cycle-count reference model.
module tb_vga_timing_gen;

  typedef struct {
    int          edge_no;
    logic        hs, vs, blank, tick, ls, fs;
    int          row, col;
    logic [23:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  done  = 1'b0;
  exp_t qa[$];
  exp_t qb[$];

  logic       a_hs, a_vs, a_blank, a_tick, a_ls, a_fs;
  logic [5:0] a_row, a_col;
  logic       b_hs, b_vs, b_blank, b_tick, b_ls, b_fs;
  logic [3:0] b_row, b_col;
  logic [23:0] a_rgb, b_rgb;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(3), .CNT_W(6), .HS_POL(1'b0), .VS_POL(1'b1)
  ) dut_a (
    .CLOCK_50(clk), .reset(reset), .HS(a_hs), .VS(a_vs), .blank(a_blank),
    .row(a_row), .col(a_col), .pix_tick(a_tick), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TEST_PATTERN_EN
    , .red(a_rgb[23:16]), .green(a_rgb[15:8]), .blue(a_rgb[7:0])
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .CNT_W(4), .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_b (
    .CLOCK_50(clk), .reset(reset), .HS(b_hs), .VS(b_vs), .blank(b_blank),
    .row(b_row), .col(b_col), .pix_tick(b_tick), .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_TEST_PATTERN_EN
    , .red(b_rgb[23:16]), .green(b_rgb[15:8]), .blue(b_rgb[7:0])
`endif
  );

`ifndef VGA_TEST_PATTERN_EN
  assign a_rgb = '0;
  assign b_rgb = '0;
`endif

  // Reference: t = cycles since the last reset edge; pixel index n = t/DIV, raster position from n.
  function automatic exp_t model(input int cfg, input int t, input int edge_no);
    int div, ha, hf, hsw, hb, va, vf, vsw, vb, hpol, vpol, ht, vt, n, h, v, barw, bar;
    bit hwin, vwin;
    exp_t e;
    if (cfg == 0) begin
      div = 3; ha = 16; hf = 2; hsw = 3; hb = 2; va = 6; vf = 1; vsw = 2; vb = 2; hpol = 0; vpol = 1;
    end else begin
      div = 1; ha = 8; hf = 1; hsw = 2; hb = 1; va = 4; vf = 1; vsw = 1; vb = 1; hpol = 1; vpol = 0;
    end
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    n  = t / div;
    h  = n % ht;
    v  = (n / ht) % vt;
    hwin = (h >= ha + hf) && (h < ha + hf + hsw);
    vwin = (v >= va + vf) && (v < va + vf + vsw);
    e.edge_no = edge_no;
    e.tick  = ((t % div) == div - 1);
    e.hs    = (hpol == 1) ? hwin : !hwin;
    e.vs    = (vpol == 1) ? vwin : !vwin;
    e.blank = (h >= ha) || (v >= va);
    e.row   = v;
    e.col   = h;
    e.ls    = e.tick && (h == 0);
    e.fs    = e.tick && (h == 0) && (v == 0);
    barw = (ha / 8 > 0) ? ha / 8 : 1;
    bar  = (h / barw > 7) ? 7 : h / barw;
    e.rgb = 24'h0;
    if (!e.blank) begin
      if (bar & 4) e.rgb[23:16] = 8'hFF;
      if (bar & 2) e.rgb[15:8]  = 8'hFF;
      if (bar & 1) e.rgb[7:0]   = 8'hFF;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int inst, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s inst%0d edge %0d: got %0h expected %0h", name, inst, edge_cnt, act, exp_v);
    end
  endtask

  task automatic compare(input int inst, input exp_t act, input exp_t e);
    chk("HS", inst, int'(act.hs), int'(e.hs));
    chk("VS", inst, int'(act.vs), int'(e.vs));
    chk("blank", inst, int'(act.blank), int'(e.blank));
    chk("row", inst, act.row, e.row);
    chk("col", inst, act.col, e.col);
    chk("pix_tick", inst, int'(act.tick), int'(e.tick));
    chk("line_start", inst, int'(act.ls), int'(e.ls));
    chk("frame_start", inst, int'(act.fs), int'(e.fs));
`ifdef VGA_TEST_PATTERN_EN
    chk("rgb", inst, int'(act.rgb), int'(e.rgb));
`endif
  endtask

  // Stimulus: random reset pulses of 1..3 cycles; each edge's expected state is queued up front.
  initial begin
    int t;
    int hold;
    t = 0;
    hold = 0;
    reset = 1'b1;
    qa.push_back(model(0, 0, 1));
    qb.push_back(model(1, 0, 1));
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc < 2) begin
        reset = 1'b1;
      end else if (hold > 0) begin
        reset = 1'b1;
        hold--;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        hold = $urandom_range(0, 2);
      end else begin
        reset = 1'b0;
      end
      t = reset ? 0 : t + 1;
      qa.push_back(model(0, t, edge_cnt + 1));
      qb.push_back(model(1, t, edge_cnt + 1));
    end
    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  always @(negedge clk) begin
    exp_t act, e;
    if (!done && qa.size() > 0 && qa[0].edge_no == edge_cnt) begin
      e = qa.pop_front();
      act.edge_no = edge_cnt;
      act.hs = a_hs; act.vs = a_vs; act.blank = a_blank; act.tick = a_tick;
      act.ls = a_ls; act.fs = a_fs; act.row = int'(a_row); act.col = int'(a_col); act.rgb = a_rgb;
      compare(0, act, e);
    end
  end

  always @(negedge clk) begin
    exp_t act, e;
    if (!done && qb.size() > 0 && qb[0].edge_no == edge_cnt) begin
      e = qb.pop_front();
      act.edge_no = edge_cnt;
      act.hs = b_hs; act.vs = b_vs; act.blank = b_blank; act.tick = b_tick;
      act.ls = b_ls; act.fs = b_fs; act.row = int'(b_row); act.col = int'(b_col); act.rgb = b_rgb;
      compare(1, act, e);
    end
  end

endmodule
